instr_loader: RTL and testbench

Boot-time loader sitting directly upstream of the instruction memory write port. Pops bytes from the UART RX FIFO, parses a 2-byte word-count header, packs each following group of 4 bytes into a 32-bit little-endian instruction, and issues one write per word at consecutive word-aligned addresses starting at 0. Signals completion or a header error to the control logic that gates CPU reset release.

---
 rtl/loader_pkg.sv | 16 +
 rtl/word_packer.sv | 39 +++
 rtl/instr_loader.sv | 140 ++++++++++++++
 tb/tb_instr_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        BYTES,
        WRITE,
        DONE
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/word_packer.sv
// Packs a stream of bytes into a 32-bit little-endian word, lane 0 first.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);

    logic [1:0]  byte_cnt;
    logic [31:0] lanes;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (load) begin
            lanes[{byte_cnt, 3'b000} +: 8] <= byte_in;
            byte_cnt                       <= byte_cnt + 2'd1;
        end
    end

    // word_out already includes the byte being loaded this cycle, so the
    // caller can capture the complete word on the same edge as the 4th pop.
    always_comb begin
        word_out = lanes;
        if (load) begin
            word_out[{byte_cnt, 3'b000} +: 8] = byte_in;
        end
    end

    // The next load completes the word; the counter then wraps to lane 0.
    assign full = (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Boot loader: reads a 2-byte word-count header from the UART FIFO, then
// packs payload bytes into words written to instruction memory from address 0.
module instr_loader
    import loader_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic                  mem_w_en,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int          IDX_W     = ADDR_WIDTH - 2;
    localparam logic [15:0] MAX_WORDS = 16'(MEM_DEPTH / BYTES_PER_WORD);

    loader_state_t    state, next_state;
    logic [15:0]      word_cnt;
    logic [15:0]      hdr_word;
    logic [IDX_W-1:0] word_idx;
    logic             pop;
    logic             accept_start;
    logic             hdr_err;
    logic             last_word;
    logic             pack_load;
    logic             pack_full;
    logic [31:0]      pack_word;

    word_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pack_load),
        .clear    (accept_start),
        .byte_in  (fifo_data),
        .word_out (pack_word),
        .full     (pack_full)
    );

    always_comb begin
        next_state   = state;
        pop          = 1'b0;
        accept_start = 1'b0;
        hdr_err      = 1'b0;
        hdr_word     = {fifo_data, word_cnt[7:0]};
        last_word    = (({{(16 - IDX_W){1'b0}}, word_idx} + 16'd1) == word_cnt);
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    next_state   = HDR_LO;
                end
            end
            HDR_LO: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = HDR_HI;
                end
            end
            HDR_HI: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (hdr_word == 16'd0) begin
                        next_state = DONE;
                    end else if (hdr_word > MAX_WORDS) begin
                        hdr_err    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = BYTES;
                    end
                end
            end
            BYTES: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (pack_full) begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE:   next_state = last_word ? DONE : BYTES;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign fifo_rd_en = pop;
    assign pack_load  = pop && (state == BYTES);

    // Status and write strobes are registered from next_state so they line
    // up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            word_cnt    <= '0;
            word_idx    <= '0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            mem_w_en    <= 1'b0;
            mem_data_in <= '0;
            mem_wr_addr <= '0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != IDLE);
            load_done <= (next_state == DONE);
            mem_w_en  <= (next_state == WRITE);
            if (accept_start) begin
                word_idx <= '0;
                load_err <= 1'b0;
            end
            if (hdr_err) begin
                load_err <= 1'b1;
            end
            if (pop && (state == HDR_LO)) begin
                word_cnt[7:0] <= fifo_data;
            end
            if (pop && (state == HDR_HI)) begin
                word_cnt[15:8] <= fifo_data;
            end
            if (next_state == WRITE) begin
                mem_data_in <= pack_word;
                mem_wr_addr <= {word_idx, 2'b00};
            end
            if (state == WRITE) begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: FIFO model, write monitor with an
// expected queue, table-driven loads and hand-written corner sequences.
`timescale 1ns/1ps
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] mem_data_in;
    logic [9:0]  mem_wr_addr;
    logic        mem_w_en;
    logic        busy;
    logic        load_done;
    logic        load_err;

    instr_loader #(
        .MEM_DEPTH  (1024),
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .fifo_data   (fifo_data),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .mem_data_in (mem_data_in),
        .mem_wr_addr (mem_wr_addr),
        .mem_w_en    (mem_w_en),
        .busy        (busy),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hdr;
        int          n_payload;
        int          n_extra;
        int          seed;
        int          exp_writes;
        bit          exp_err;
        int          exp_left;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    int checks = 0;
    int errors = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  pay[$];
    logic [41:0] exp_q[$];
    logic [41:0] obs_q[$];

    bit   popped = 1'b0;
    int   pops = 0;
    int   pop_base = 0;
    int   cyc = 0;
    int   rd_guard_viol = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   busy_fall_cyc = -1;
    int   last_wr_cyc = -1;
    int   hdr_hi_cyc = -1;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc++;

    // FIFO model: commits the pop decided before the previous rising edge,
    // then presents the new head and samples the pop strobe for the next edge.
    always @(negedge clk) begin
        #1;
        if (popped) void'(fifo_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
        #1;
        if (fifo_rd_en && fifo_empty) rd_guard_viol++;
        popped = fifo_rd_en && !fifo_empty && rst_n;
        if (popped) begin
            pops++;
            if (pops == pop_base + 2) hdr_hi_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (mem_w_en) begin
            obs_q.push_back({mem_wr_addr, mem_data_in});
            last_wr_cyc = cyc;
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [41:0] obs_at(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return 'x;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_load_done"},   64'(load_done),   64'd0);
        check({tag, "_load_err"},    64'(load_err),    64'd0);
        check({tag, "_mem_w_en"},    64'(mem_w_en),    64'd0);
        check({tag, "_fifo_rd_en"},  64'(fifo_rd_en),  64'd0);
        check({tag, "_mem_data_in"}, 64'(mem_data_in), 64'd0);
        check({tag, "_mem_wr_addr"}, 64'(mem_wr_addr), 64'd0);
    endtask

    task automatic clear_mon();
        obs_q.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        busy_fall_cyc = -1;
        last_wr_cyc   = -1;
        hdr_hi_cyc    = -1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        pop_base = pops;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        #2;
        check({tag, "_timeout"}, 64'(n < limit), 64'd1);
    endtask

    // Runs one load from the current fifo_q contents against exp_q.
    task automatic run_load(input string tag, input int exp_writes, input bit exp_err,
                            input int exp_left);
        clear_mon();
        pulse_start();
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        check({tag, "_err_clear"}, 64'(load_err), 64'd0);
        wait_idle(tag, 3000);
        check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_writes));
        for (int i = 0; i < exp_writes; i++) begin
            if (obs_at(i) !== exp_q[i]) begin
                check($sformatf("%s_write%0d", tag, i), 64'(obs_at(i)), 64'(exp_q[i]));
            end
        end
        if (exp_writes > 0) begin
            check({tag, "_last_write"}, 64'(obs_at(exp_writes - 1)), 64'(exp_q[exp_writes - 1]));
        end
        check({tag, "_done_cnt"}, 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
        check({tag, "_load_err"}, 64'(load_err), 64'(exp_err));
        check({tag, "_fifo_left"}, 64'(fifo_q.size()), 64'(exp_left));
        if (exp_err) begin
            check({tag, "_err_busy_fall"}, 64'(busy_fall_cyc), 64'(hdr_hi_cyc + 1));
        end else if (exp_writes == 0) begin
            check({tag, "_zero_done_cyc"}, 64'(done_cyc), 64'(hdr_hi_cyc + 1));
            check({tag, "_zero_busy_fall"}, 64'(busy_fall_cyc), 64'(hdr_hi_cyc + 2));
        end else begin
            check({tag, "_done_after_write"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
            check({tag, "_busy_fall"}, 64'(busy_fall_cyc), 64'(last_wr_cyc + 2));
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{16'h0001,    4, 0, 1,   1, 1'b0, 0};
        vecs[1] = '{16'h0003,   12, 2, 2,   3, 1'b0, 2};
        vecs[2] = '{16'h0000,    0, 3, 3,   0, 1'b0, 3};
        vecs[3] = '{16'h0101,    0, 6, 4,   0, 1'b1, 6};
        vecs[4] = '{16'h0004,   16, 0, 5,   4, 1'b0, 0};
        vecs[5] = '{16'hFFFF,    0, 2, 6,   0, 1'b1, 2};
        vecs[6] = '{16'h0100, 1024, 0, 7, 256, 1'b0, 0};
        vecs[7] = '{16'h0007,   28, 1, 8,   7, 1'b0, 1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Two-instruction example load.
        fifo_q = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_q.delete();
        exp_q.push_back({10'h000, 32'h00000513});
        exp_q.push_back({10'h004, 32'h00100093});
        run_load("example", 2, 1'b0, 0);

        for (int v = 0; v < NV; v++) begin
            fifo_q.delete();
            exp_q.delete();
            pay.delete();
            fifo_q.push_back(vecs[v].hdr[7:0]);
            fifo_q.push_back(vecs[v].hdr[15:8]);
            for (int k = 0; k < vecs[v].n_payload + vecs[v].n_extra; k++) begin
                pay.push_back(8'((k * 29 + vecs[v].seed * 53 + 7) & 255));
                fifo_q.push_back(pay[k]);
            end
            for (int w = 0; w < vecs[v].exp_writes; w++) begin
                exp_q.push_back({10'(w * 4), pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]});
            end
            run_load($sformatf("vec%0d", v), vecs[v].exp_writes, vecs[v].exp_err,
                     vecs[v].exp_left);
        end

        // FIFO runs dry between bytes 2 and 3; start pulses during the stall.
        fifo_q = {8'h01, 8'h00, 8'haa, 8'hbb};
        clear_mon();
        pulse_start();
        n = 0;
        while (pops < pop_base + 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_reach", 64'(n < 100), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = (i == 1);
            #2;
            check($sformatf("stall_rd_en%0d", i), 64'(fifo_rd_en), 64'd0);
            check($sformatf("stall_busy%0d", i), 64'(busy), 64'd1);
        end
        @(negedge clk);
        start = 1'b0;
        fifo_q.push_back(8'hcc);
        fifo_q.push_back(8'hdd);
        wait_idle("stall", 200);
        check("stall_nwrites", 64'(obs_q.size()), 64'd1);
        check("stall_word", 64'(obs_at(0)), 64'({10'h000, 32'hddccbbaa}));
        check("stall_done", 64'(done_cnt), 64'd1);
        repeat (3) @(negedge clk);
        check("stall_no_restart", 64'(busy), 64'd0);
        check("stall_no_extra_write", 64'(obs_q.size()), 64'd1);

        // Reset after the second byte of word 1.
        fifo_q = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_mon();
        pulse_start();
        n = 0;
        while (pops < pop_base + 8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach", 64'(n < 100), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        #2;
        check("rst_nwrites", 64'(obs_q.size()), 64'd1);
        check("rst_word0", 64'(obs_at(0)), 64'({10'h000, 32'h44332211}));
        @(negedge clk);
        rst_n = 1'b1;
        fifo_q = {8'h01, 8'h00, 8'hde, 8'had, 8'hbe, 8'hef};
        exp_q.delete();
        exp_q.push_back({10'h000, 32'hefbeadde});
        run_load("after_reset", 1, 1'b0, 0);

        check("rd_en_guard", 64'(rd_guard_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
